// File: rtl/self_trigger_detector.sv
// self_trigger_detector
// ---------------------
// Qualifies the ADC sample stream against a programmable threshold and emits a
// one-cycle `triggered` pulse for the self-trigger state machine. The pulse can
// only occur while `armed` (the state machine's waitForTrigger) is high. The
// block adds re-arm protection, glitch qualification and a post-trigger holdoff.
//
// Ports:
//   clk            system clock, rising edge
//   rst            synchronous active-high reset
//   adcData        unsigned offset-binary ADC sample
//   adcValid       adcData is valid this cycle
//   armed          waitForTrigger from the self-trigger state machine
//   threshold      trigger level (latched when leaving IDLE)
//   edgeSelect     0 = rising, 1 = falling (latched when leaving IDLE)
//   qualifyCount   consecutive beyond-threshold samples required, 0 acts as 1
//   holdoffCycles  clocks spent in HOLDOFF after a trigger (latched on FIRE exit)
//   triggered      one-cycle trigger pulse
//   triggerSample  sample that completed qualification
//   triggerCount   number of triggers fired, wraps modulo 2^16
//   busy           state is not IDLE
module self_trigger_detector #(
  parameter int DATA_WIDTH    = 8,
  parameter int QUAL_WIDTH    = 4,
  parameter int HOLDOFF_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_WIDTH-1:0]    adcData,
  input  logic                     adcValid,
  input  logic                     armed,
  input  logic [DATA_WIDTH-1:0]    threshold,
  input  logic                     edgeSelect,
  input  logic [QUAL_WIDTH-1:0]    qualifyCount,
  input  logic [HOLDOFF_WIDTH-1:0] holdoffCycles,
  output logic                     triggered,
  output logic [DATA_WIDTH-1:0]    triggerSample,
  output logic [15:0]              triggerCount,
  output logic                     busy
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SEEK    = 3'd1,
    QUALIFY = 3'd2,
    FIRE    = 3'd3,
    HOLDOFF = 3'd4
  } state_t;

  state_t                   state_q, state_d;
  logic [DATA_WIDTH-1:0]    thr_q, thr_d;
  logic                     edge_sel_q, edge_sel_d;
  logic [QUAL_WIDTH-1:0]    qual_q, qual_d;
  logic [QUAL_WIDTH-1:0]    qcnt_q, qcnt_d;
  logic [HOLDOFF_WIDTH-1:0] hold_cnt_q, hold_cnt_d;
  logic [DATA_WIDTH-1:0]    trig_sample_q, trig_sample_d;
  logic [15:0]              trig_count_q, trig_count_d;

  logic                     beyond;
  logic [QUAL_WIDTH-1:0]    qual_eff;
  logic [QUAL_WIDTH-1:0]    qcnt_inc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      thr_q         <= '0;
      edge_sel_q    <= 1'b0;
      qual_q        <= '0;
      qcnt_q        <= '0;
      hold_cnt_q    <= '0;
      trig_sample_q <= '0;
      trig_count_q  <= '0;
    end else begin
      state_q       <= state_d;
      thr_q         <= thr_d;
      edge_sel_q    <= edge_sel_d;
      qual_q        <= qual_d;
      qcnt_q        <= qcnt_d;
      hold_cnt_q    <= hold_cnt_d;
      trig_sample_q <= trig_sample_d;
      trig_count_q  <= trig_count_d;
    end
  end

  // Classification uses the latched config; "before" is simply !beyond, so the
  // threshold value itself is always a before-sample in either direction.
  always_comb begin
    beyond   = edge_sel_q ? (adcData < thr_q) : (adcData > thr_q);
    qual_eff = (qual_q == '0) ? QUAL_WIDTH'(1) : qual_q;
    qcnt_inc = (qcnt_q == '1) ? qcnt_q : QUAL_WIDTH'(qcnt_q + 1'b1);
  end

  always_comb begin
    state_d       = state_q;
    thr_d         = thr_q;
    edge_sel_d    = edge_sel_q;
    qual_d        = qual_q;
    qcnt_d        = qcnt_q;
    hold_cnt_d    = hold_cnt_q;
    trig_sample_d = trig_sample_q;
    trig_count_d  = trig_count_q;

    case (state_q)
      IDLE: begin
        if (armed) begin
          state_d    = SEEK;
          thr_d      = threshold;
          edge_sel_d = edgeSelect;
          qual_d     = qualifyCount;
          qcnt_d     = '0;
        end
      end

      // A signal already beyond threshold must first cross back before it can
      // start a qualification run.
      SEEK: begin
        if (!armed) begin
          state_d = IDLE;
        end else if (adcValid && !beyond) begin
          state_d = QUALIFY;
          qcnt_d  = '0;
        end
      end

      // Invalid cycles hold the run count; a valid before-sample restarts it.
      QUALIFY: begin
        if (!armed) begin
          state_d = IDLE;
          qcnt_d  = '0;
        end else if (adcValid) begin
          if (beyond) begin
            qcnt_d = qcnt_inc;
            if (qcnt_inc >= qual_eff) begin
              state_d       = FIRE;
              trig_sample_d = adcData;
              trig_count_d  = trig_count_q + 16'd1;
            end
          end else begin
            qcnt_d = '0;
          end
        end
      end

      FIRE: begin
        qcnt_d = '0;
        if (holdoffCycles != '0) begin
          state_d    = HOLDOFF;
          hold_cnt_d = holdoffCycles;
        end else begin
          state_d = IDLE;
        end
      end

      // Leaving when the counter shows 1 gives exactly holdoffCycles clocks here.
      HOLDOFF: begin
        if (hold_cnt_q <= HOLDOFF_WIDTH'(1)) begin
          state_d    = IDLE;
          hold_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q - HOLDOFF_WIDTH'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign triggered     = (state_q == FIRE);
  assign busy          = (state_q != IDLE);
  assign triggerSample = trig_sample_q;
  assign triggerCount  = trig_count_q;

endmodule

// File: tb/tb_self_trigger_detector.sv
// tb_self_trigger_detector
// ------------------------
// Directed bench for self_trigger_detector: a table of per-cycle vectors with
// hand-computed outputs, followed by hand-written multi-cycle sequences for
// arm-while-high, holdoff, disarm, reset and counter wrap.
module tb_self_trigger_detector;

  logic        clk;
  logic        rst;
  logic [7:0]  adc_data;
  logic        adc_valid;
  logic        armed;
  logic [7:0]  threshold;
  logic        edge_select;
  logic [3:0]  qualify_count;
  logic [15:0] holdoff_cycles;
  logic        triggered;
  logic [7:0]  trigger_sample;
  logic [15:0] trigger_count;
  logic        busy;

  int checks;
  int errors;

  typedef struct {
    logic        rst;
    logic        armed;
    logic        valid;
    logic [7:0]  data;
    logic [7:0]  thr;
    logic        edge_sel;
    logic [3:0]  qual;
    logic [15:0] hold;
    logic        exp_trig;
    logic        exp_busy;
    logic [7:0]  exp_sample;
    logic [15:0] exp_count;
  } vec_t;

  localparam int NVEC = 30;
  vec_t vecs [NVEC];

  self_trigger_detector #(
    .DATA_WIDTH(8),
    .QUAL_WIDTH(4),
    .HOLDOFF_WIDTH(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .adcData(adc_data),
    .adcValid(adc_valid),
    .armed(armed),
    .threshold(threshold),
    .edgeSelect(edge_select),
    .qualifyCount(qualify_count),
    .holdoffCycles(holdoff_cycles),
    .triggered(triggered),
    .triggerSample(trigger_sample),
    .triggerCount(trigger_count),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic a, input logic v,
                              input logic [7:0] d, input logic [7:0] t,
                              input logic e, input logic [3:0] q,
                              input logic [15:0] h, input logic et,
                              input logic eb, input logic [7:0] es,
                              input logic [15:0] ec);
    vec_t x;
    x.rst = r; x.armed = a; x.valid = v; x.data = d; x.thr = t;
    x.edge_sel = e; x.qual = q; x.hold = h;
    x.exp_trig = et; x.exp_busy = eb; x.exp_sample = es; x.exp_count = ec;
    return x;
  endfunction

  // One clock: inputs already driven, outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input vec_t x);
    rst            = x.rst;
    armed          = x.armed;
    adc_valid      = x.valid;
    adc_data       = x.data;
    threshold      = x.thr;
    edge_select    = x.edge_sel;
    qualify_count  = x.qual;
    holdoff_cycles = x.hold;
    step();
  endtask

  task automatic check_output(input string name, input logic [15:0] actual,
                              input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    rst            = 1'b1;
    armed          = 1'b0;
    adc_valid      = 1'b0;
    adc_data       = 8'h00;
    threshold      = 8'h80;
    edge_select    = 1'b0;
    qualify_count  = 4'd1;
    holdoff_cycles = 16'd0;

    //                rst arm val data   thr  e  q     hold   trg bsy smp    cnt
    // reset
    vecs[0]  = mk(1, 0, 0, 8'h00, 8'h80, 0, 4'd1, 16'd0, 0, 0, 8'h00, 16'd0);
    // rising edge, qualify 1
    vecs[1]  = mk(0, 1, 0, 8'h00, 8'h80, 0, 4'd1, 16'd0, 0, 1, 8'h00, 16'd0);
    vecs[2]  = mk(0, 1, 1, 8'h10, 8'h80, 0, 4'd1, 16'd0, 0, 1, 8'h00, 16'd0);
    vecs[3]  = mk(0, 1, 1, 8'h7F, 8'h80, 0, 4'd1, 16'd0, 0, 1, 8'h00, 16'd0);
    vecs[4]  = mk(0, 1, 1, 8'h81, 8'h80, 0, 4'd1, 16'd0, 1, 1, 8'h81, 16'd1);
    vecs[5]  = mk(0, 0, 0, 8'h00, 8'h80, 0, 4'd1, 16'd0, 0, 0, 8'h81, 16'd1);
    vecs[6]  = mk(0, 0, 0, 8'h00, 8'h80, 0, 4'd1, 16'd0, 0, 0, 8'h81, 16'd1);
    // glitch rejection, qualify 3
    vecs[7]  = mk(0, 1, 0, 8'h00, 8'h80, 0, 4'd3, 16'd0, 0, 1, 8'h81, 16'd1);
    vecs[8]  = mk(0, 1, 1, 8'h90, 8'h80, 0, 4'd3, 16'd0, 0, 1, 8'h81, 16'd1);
    vecs[9]  = mk(0, 1, 1, 8'h90, 8'h80, 0, 4'd3, 16'd0, 0, 1, 8'h81, 16'd1);
    vecs[10] = mk(0, 1, 1, 8'h70, 8'h80, 0, 4'd3, 16'd0, 0, 1, 8'h81, 16'd1);
    vecs[11] = mk(0, 1, 1, 8'h90, 8'h80, 0, 4'd3, 16'd0, 0, 1, 8'h81, 16'd1);
    vecs[12] = mk(0, 1, 1, 8'h90, 8'h80, 0, 4'd3, 16'd0, 0, 1, 8'h81, 16'd1);
    vecs[13] = mk(0, 1, 1, 8'h90, 8'h80, 0, 4'd3, 16'd0, 1, 1, 8'h90, 16'd2);
    vecs[14] = mk(0, 0, 0, 8'h00, 8'h80, 0, 4'd3, 16'd0, 0, 0, 8'h90, 16'd2);
    // gaps hold the run, a before-sample restarts it
    vecs[15] = mk(0, 1, 0, 8'h00, 8'h80, 0, 4'd3, 16'd0, 0, 1, 8'h90, 16'd2);
    vecs[16] = mk(0, 1, 1, 8'h70, 8'h80, 0, 4'd3, 16'd0, 0, 1, 8'h90, 16'd2);
    vecs[17] = mk(0, 1, 1, 8'h90, 8'h80, 0, 4'd3, 16'd0, 0, 1, 8'h90, 16'd2);
    vecs[18] = mk(0, 1, 0, 8'h90, 8'h80, 0, 4'd3, 16'd0, 0, 1, 8'h90, 16'd2);
    vecs[19] = mk(0, 1, 1, 8'h70, 8'h80, 0, 4'd3, 16'd0, 0, 1, 8'h90, 16'd2);
    vecs[20] = mk(0, 1, 1, 8'h90, 8'h80, 0, 4'd3, 16'd0, 0, 1, 8'h90, 16'd2);
    vecs[21] = mk(0, 1, 0, 8'h90, 8'h80, 0, 4'd3, 16'd0, 0, 1, 8'h90, 16'd2);
    vecs[22] = mk(0, 1, 1, 8'h90, 8'h80, 0, 4'd3, 16'd0, 0, 1, 8'h90, 16'd2);
    vecs[23] = mk(0, 1, 1, 8'h95, 8'h80, 0, 4'd3, 16'd0, 1, 1, 8'h95, 16'd3);
    vecs[24] = mk(0, 0, 0, 8'h00, 8'h80, 0, 4'd3, 16'd0, 0, 0, 8'h95, 16'd3);
    // falling edge, qualify 0 acts as 1, threshold change while busy ignored
    vecs[25] = mk(0, 1, 0, 8'h00, 8'h40, 1, 4'd0, 16'd0, 0, 1, 8'h95, 16'd3);
    vecs[26] = mk(0, 1, 1, 8'h60, 8'h40, 1, 4'd0, 16'd0, 0, 1, 8'h95, 16'd3);
    vecs[27] = mk(0, 1, 1, 8'h40, 8'h50, 1, 4'd0, 16'd0, 0, 1, 8'h95, 16'd3);
    vecs[28] = mk(0, 1, 1, 8'h3F, 8'h50, 1, 4'd0, 16'd0, 1, 1, 8'h3F, 16'd4);
    vecs[29] = mk(0, 0, 0, 8'h00, 8'h40, 1, 4'd0, 16'd0, 0, 0, 8'h3F, 16'd4);

    for (int i = 0; i < NVEC; i++) begin
      apply_stimulus(vecs[i]);
      check_output($sformatf("vec%0d trig", i), 16'(triggered), 16'(vecs[i].exp_trig));
      check_output($sformatf("vec%0d busy", i), 16'(busy), 16'(vecs[i].exp_busy));
      check_output($sformatf("vec%0d sample", i), 16'(trigger_sample), 16'(vecs[i].exp_sample));
      check_output($sformatf("vec%0d count", i), trigger_count, vecs[i].exp_count);
    end

    // Already above threshold at arm time: no trigger until it crosses back.
    threshold = 8'h80; edge_select = 1'b0; qualify_count = 4'd1;
    holdoff_cycles = 16'd0; armed = 1'b1; adc_valid = 1'b1; adc_data = 8'hF0;
    for (int i = 0; i < 50; i++) begin
      step();
      check_output($sformatf("high%0d trig", i), 16'(triggered), 16'd0);
    end
    check_output("high busy", 16'(busy), 16'd1);
    adc_data = 8'h20; step();
    check_output("high cross trig", 16'(triggered), 16'd0);
    adc_data = 8'h90; step();
    check_output("high fire trig", 16'(triggered), 16'd1);
    check_output("high fire sample", 16'(trigger_sample), 16'h0090);
    check_output("high fire count", trigger_count, 16'd5);
    armed = 1'b0; adc_valid = 1'b0; step();
    check_output("high idle busy", 16'(busy), 16'd0);

    // Holdoff of 5 with armed held high, then a second trigger.
    holdoff_cycles = 16'd5; armed = 1'b1; adc_valid = 1'b1; adc_data = 8'h20;
    step();
    step();
    adc_data = 8'h90; step();
    check_output("hold fire1 trig", 16'(triggered), 16'd1);
    check_output("hold fire1 count", trigger_count, 16'd6);
    for (int i = 0; i < 5; i++) begin
      adc_data = (i % 2 == 0) ? 8'h20 : 8'h90;
      step();
      if (i == 0) holdoff_cycles = 16'd1;
      check_output($sformatf("hold%0d busy", i), 16'(busy), 16'd1);
      check_output($sformatf("hold%0d trig", i), 16'(triggered), 16'd0);
    end
    step();
    check_output("hold end busy", 16'(busy), 16'd0);
    step();
    check_output("hold rearm busy", 16'(busy), 16'd1);
    adc_data = 8'h20; step();
    adc_data = 8'h90; holdoff_cycles = 16'd0; step();
    check_output("hold fire2 trig", 16'(triggered), 16'd1);
    check_output("hold fire2 count", trigger_count, 16'd7);
    armed = 1'b0; step();
    check_output("hold fire2 idle", 16'(busy), 16'd0);

    // Dropping armed during QUALIFY returns to IDLE with no trigger.
    armed = 1'b1; adc_data = 8'h20; step();
    step();
    armed = 1'b0; adc_data = 8'h90; step();
    check_output("disarm trig", 16'(triggered), 16'd0);
    check_output("disarm busy", 16'(busy), 16'd0);
    step();
    check_output("disarm trig2", 16'(triggered), 16'd0);
    check_output("disarm count", trigger_count, 16'd7);

    // Reset in QUALIFY with two beyond-samples counted out of three.
    qualify_count = 4'd3; armed = 1'b1; adc_data = 8'h20; step();
    step();
    adc_data = 8'h90; step();
    step();
    rst = 1'b1; step();
    check_output("rst trig", 16'(triggered), 16'd0);
    check_output("rst busy", 16'(busy), 16'd0);
    check_output("rst sample", 16'(trigger_sample), 16'd0);
    check_output("rst count", trigger_count, 16'd0);
    rst = 1'b0; armed = 1'b0; step();
    check_output("rst after busy", 16'(busy), 16'd0);

    // Counter wrap from 0xFFFF.
    force dut.trig_count_q = 16'hFFFF;
    step();
    release dut.trig_count_q;
    check_output("wrap preload", trigger_count, 16'hFFFF);
    qualify_count = 4'd1; armed = 1'b1; adc_data = 8'h20; step();
    step();
    adc_data = 8'h90; step();
    check_output("wrap trig", 16'(triggered), 16'd1);
    check_output("wrap count", trigger_count, 16'h0000);
    armed = 1'b0; step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
